reg_port_ctrl: RTL and testbench

Initiator for the single-port register file: it accepts one operand/writeback request per transaction and sequences the file's `op`/`rw`/`reg_idx`/`data_w` port. One request covers an optional writeback of `rd` and up to two operand reads (`rs1`, `rs2`). The block captures `data_r` and returns both operands on a valid/ready response channel. It sits between the core's decode/writeback logic and the register file, and it enforces x0 semantics because the file does not.

---
 rtl/reg_port_ctrl.sv | 112 +++++++++++
 tb/tb_reg_port_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/reg_port_ctrl.sv
// reg_port_ctrl: sequences writeback and operand reads on a single-port register file
module reg_port_ctrl #(
  parameter int REG_IDX_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_wr_en,
  input  logic [REG_IDX_WIDTH-1:0] req_rd,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic                     req_rs1_en,
  input  logic                     req_rs2_en,
  input  logic [REG_IDX_WIDTH-1:0] req_rs1,
  input  logic [REG_IDX_WIDTH-1:0] req_rs2,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rs1_data,
  output logic [DATA_WIDTH-1:0]    resp_rs2_data,
  output logic                     rf_op,
  output logic                     rf_rw,
  output logic [REG_IDX_WIDTH-1:0] rf_reg_idx,
  output logic [DATA_WIDTH-1:0]    rf_data_w,
  input  logic [DATA_WIDTH-1:0]    rf_data_r
);
  typedef enum logic [2:0] {IDLE, WR, RD1, RD2, RESP} state_t;
  state_t                   state_q, state_d;
  logic                     wr_en_q, wr_en_d, rs1_en_q, rs1_en_d, rs2_en_q, rs2_en_d;
  logic [REG_IDX_WIDTH-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic                     go_wr, go_rd1, go_rd2;
  assign go_wr  = req_wr_en && req_rd != '0;
  assign go_rd1 = rs1_en_q && rs1_q != '0;
  assign go_rd2 = rs2_en_q && rs2_q != '0;
  // next-state: latch on accept, skip x0/disabled accesses, capture read data on leaving a read
  always_comb begin
    state_d    = state_q;
    wr_en_d    = wr_en_q;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    rs1_en_d   = rs1_en_q;
    rs1_d      = rs1_q;
    rs2_en_d   = rs2_en_q;
    rs2_d      = rs2_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    case (state_q)
      IDLE: if (req_valid) begin
        wr_en_d    = req_wr_en;
        rd_d       = req_rd;
        wdata_d    = req_wdata;
        rs1_en_d   = req_rs1_en;
        rs1_d      = req_rs1;
        rs2_en_d   = req_rs2_en;
        rs2_d      = req_rs2;
        rs1_data_d = '0;
        rs2_data_d = '0;
        state_d    = go_wr ? WR :
                     (req_rs1_en && req_rs1 != '0) ? RD1 :
                     (req_rs2_en && req_rs2 != '0) ? RD2 : RESP;
      end
      WR:   state_d = go_rd1 ? RD1 : go_rd2 ? RD2 : RESP;
      RD1: begin
        rs1_data_d = rf_data_r;
        state_d    = go_rd2 ? RD2 : RESP;
      end
      RD2: begin
        rs2_data_d = rf_data_r;
        state_d    = RESP;
      end
      RESP: state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // state and latched fields; reset aborts and clears captured data
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      wr_en_q    <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
      rs1_en_q   <= 1'b0;
      rs1_q      <= '0;
      rs2_en_q   <= 1'b0;
      rs2_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      rs1_en_q   <= rs1_en_d;
      rs1_q      <= rs1_d;
      rs2_en_q   <= rs2_en_d;
      rs2_q      <= rs2_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
    end
  end
  assign req_ready     = state_q == IDLE;
  assign resp_valid    = state_q == RESP;
  assign resp_rs1_data = rs1_data_q;
  assign resp_rs2_data = rs2_data_q;
  assign rf_op         = state_q == WR || state_q == RD1 || state_q == RD2;
  assign rf_rw         = state_q == WR;
  assign rf_reg_idx    = state_q == WR ? rd_q : state_q == RD1 ? rs1_q : state_q == RD2 ? rs2_q : '0;
  assign rf_data_w     = state_q == WR ? wdata_q : '0;
  logic unused;
  assign unused = wr_en_q;
endmodule

// File: tb/tb_reg_port_ctrl.sv
// tb_reg_port_ctrl: directed vectors and corner sequences against a behavioral register file
module tb_reg_port_ctrl;
  logic        sys_clk = 1'b0, sys_rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_wr_en = 1'b0, req_rs1_en = 1'b0, req_rs2_en = 1'b0;
  logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0, rf_reg_idx;
  logic [31:0] req_wdata = '0, resp_rs1_data, resp_rs2_data, rf_data_w, rf_data_r = '0;
  logic        resp_valid, resp_ready = 1'b0, rf_op, rf_rw;
  int          total = 0, bad = 0;
  typedef struct {
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        e1;
    logic [4:0]  s1;
    logic        e2;
    logic [4:0]  s2;
    int          n;
    logic [31:0] x1;
    logic [31:0] x2;
  } vec_t;
  vec_t v [9];
  logic [31:0] mem [32];
  logic        mem_init = 1'b0;
  reg_port_ctrl dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr_en(req_wr_en), .req_rd(req_rd), .req_wdata(req_wdata),
    .req_rs1_en(req_rs1_en), .req_rs2_en(req_rs2_en), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rs1_data(resp_rs1_data), .resp_rs2_data(resp_rs2_data),
    .rf_op(rf_op), .rf_rw(rf_rw), .rf_reg_idx(rf_reg_idx), .rf_data_w(rf_data_w), .rf_data_r(rf_data_r)
  );
  always #5 sys_clk = ~sys_clk;
  // register file: xN = N-1, x0 holds junk since the file does not enforce x0
  always @(negedge sys_clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] = i - 1;
      mem[0] = 32'hFFFF_FFFF;
      mem_init = 1'b1;
    end
    if (rf_op && rf_rw && !sys_rst) mem[rf_reg_idx] = rf_data_w;
    rf_data_r <= mem[rf_reg_idx];
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic drive(input vec_t t);
    req_valid  = 1'b1;
    req_wr_en  = t.wr;
    req_rd     = t.rd;
    req_wdata  = t.wd;
    req_rs1_en = t.e1;
    req_rs1    = t.s1;
    req_rs2_en = t.e2;
    req_rs2    = t.s2;
  endtask
  task automatic txn(input vec_t t, input string nm);
    int cyc, ops;
    drive(t);
    resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    cyc = 0;
    ops = 0;
    while (!resp_valid && cyc < 10) begin
      ops += int'(rf_op);
      tick();
      cyc++;
    end
    chk({nm, " latency"}, cyc, t.n);
    chk({nm, " accesses"}, ops, t.n);
    chk({nm, " rs1"}, resp_rs1_data, t.x1);
    chk({nm, " rs2"}, resp_rs2_data, t.x2);
    tick();
    chk({nm, " idle"}, {resp_valid, req_ready}, 2'b01);
  endtask
  initial begin
    vec_t t;
    int cyc;
    v[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  1'b1, 5'd3,  3, 32'hDEADBEEF, 32'd2};
    v[1] = '{1'b1, 5'd0,  32'h00001234, 1'b1, 5'd0,  1'b1, 5'd2,  1, 32'd0, 32'd1};
    v[2] = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd0,  1'b1, 5'd0,  0, 32'd0, 32'd0};
    v[3] = '{1'b0, 5'd7,  32'd55,       1'b0, 5'd4,  1'b0, 5'd6,  0, 32'd0, 32'd0};
    v[4] = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  1'b1, 5'd10, 1, 32'd0, 32'd9};
    v[5] = '{1'b1, 5'd9,  32'h0000A5A5, 1'b0, 5'd1,  1'b1, 5'd9,  2, 32'd0, 32'h0000A5A5};
    v[6] = '{1'b1, 5'd12, 32'h00000077, 1'b0, 5'd0,  1'b0, 5'd0,  1, 32'd0, 32'd0};
    v[7] = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd12, 1'b1, 5'd5,  2, 32'h00000077, 32'hDEADBEEF};
    v[8] = '{1'b0, 5'd7,  32'd0,        1'b1, 5'd7,  1'b0, 5'd5,  1, 32'd6, 32'd0};
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    chk("reset ready/valid", {req_ready, resp_valid}, 2'b10);
    chk("reset rf op/rw", {rf_op, rf_rw}, 2'b00);
    chk("reset rf idx", rf_reg_idx, 0);
    chk("reset rf data_w", rf_data_w, 0);
    chk("reset rs1", resp_rs1_data, 0);
    chk("reset rs2", resp_rs2_data, 0);
    t = '{1'b1, 5'd8, 32'hCAFEF00D, 1'b1, 5'd8, 1'b1, 5'd3, 3, 32'hCAFEF00D, 32'd2};
    drive(t);
    resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("seq wr", {rf_op, rf_rw, 3'b0, rf_reg_idx, rf_data_w}, {2'b11, 3'b0, 5'd8, 32'hCAFEF00D});
    chk("seq wr busy", {req_ready, resp_valid}, 2'b00);
    tick();
    chk("seq rd1", {rf_op, rf_rw, 3'b0, rf_reg_idx, rf_data_w}, {2'b10, 3'b0, 5'd8, 32'd0});
    tick();
    chk("seq rd2", {rf_op, rf_rw, 3'b0, rf_reg_idx, rf_data_w}, {2'b10, 3'b0, 5'd3, 32'd0});
    tick();
    chk("seq resp", {resp_valid, rf_op, req_ready}, 3'b100);
    chk("seq rs1", resp_rs1_data, 32'hCAFEF00D);
    chk("seq rs2", resp_rs2_data, 32'd2);
    tick();
    chk("seq idle", {resp_valid, req_ready}, 2'b01);
    for (int i = 0; i < 9; i++) txn(v[i], $sformatf("vec%0d", i));
    t = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd0, 1, 32'd2, 32'd0};
    drive(t);
    resp_ready = 1'b0;
    tick();
    t = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 1'b0, 5'd0, 1, 32'd1, 32'd0};
    drive(t);
    cyc = 0;
    while (!resp_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("bp latency", cyc, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp hold", {resp_valid, req_ready}, 2'b10);
      chk("bp data", resp_rs1_data, 32'd2);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    chk("bp release", {resp_valid, req_ready}, 2'b01);
    chk("bp data kept", resp_rs1_data, 32'd2);
    tick();
    chk("bp accepted", req_ready, 1'b0);
    req_valid = 1'b0;
    cyc = 0;
    while (!resp_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("bp second rs1", resp_rs1_data, 32'd1);
    tick();
    t = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b1, 5'd4, 2, 32'd2, 32'd3};
    drive(t);
    tick();
    req_valid = 1'b0;
    chk("rst rd1", {rf_op, rf_rw, 3'b0, rf_reg_idx}, {2'b10, 3'b0, 5'd3});
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("rst idle", {req_ready, rf_op, resp_valid}, 3'b100);
    chk("rst rs1", resp_rs1_data, 0);
    chk("rst rs2", resp_rs2_data, 0);
    for (int i = 0; i < 4; i++) begin
      chk("rst no resp", resp_valid, 1'b0);
      tick();
    end
    t = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 1'b1, 5'd7, 2, 32'd5, 32'd6};
    txn(t, "after rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
